cpu_ctrl: RTL and testbench

Multicycle control unit for the RV32I datapath: `pc`, instruction memory, `Reg` register file, ALU, write-back multiplexer and data `memory`. It sequences each instruction through fetch, decode, execute, memory and write-back states. It handshakes with both memories, which may take a variable number of cycles. It drives every datapath enable and select, and halts on `ecall`, illegal opcode or memory timeout.

---
 rtl/cpu_pkg.sv | 41 ++++
 rtl/cpu_ctrl_timer.sv | 28 ++
 rtl/cpu_ctrl.sv | 177 +++++++++++++++++
 tb/tb_cpu_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared states, opcodes and encodings for the RV32I multicycle controller
package cpu_pkg;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;

    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JAL    = 2'd2;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    localparam logic [1:0] ERR_ECALL   = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    function automatic logic is_exec_op(input logic [6:0] op);
        return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) ||
               (op == OP_STORE) || (op == OP_BRANCH) || (op == OP_JAL);
    endfunction

endpackage

// File: rtl/cpu_ctrl_timer.sv
// rtl/cpu_ctrl_timer.sv - memory wait counter; expired once TIMEOUT unanswered cycles have elapsed
module cpu_ctrl_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic hold,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (hold && !expired) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign expired = (r_cnt == W'(TIMEOUT));

endmodule

// File: rtl/cpu_ctrl.sv
// rtl/cpu_ctrl.sv - multicycle RV32I control FSM driving datapath enables and memory handshakes
module cpu_ctrl
    import cpu_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [31:0] instr,
    input  logic        branch_taken,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        imem_req,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        RegWrite,
    output logic        alu_src,
    output logic [3:0]  alu_op,
    output logic [1:0]  wb_sel,
    output logic        halted,
    output logic [1:0]  err
);

    state_t     r_state;
    logic       r_fetch_busy;
    logic       r_halted;
    logic [1:0] r_err;

    logic [6:0] w_op;
    logic [2:0] w_f3;
    logic       w_f7b5;
    logic       w_fetch_phase;
    logic       w_mem_phase;
    logic       w_ready;
    logic       w_expired;
    logic       w_unused;

    assign w_op     = instr[6:0];
    assign w_f3     = instr[14:12];
    assign w_f7b5   = instr[30];
    assign w_unused = ^{instr[31], instr[29:15], instr[11:7]};

    // Once a fetch has been issued it must finish or time out regardless of run.
    assign w_fetch_phase = (r_state == S_FETCH) && (run || r_fetch_busy);
    assign w_mem_phase   = (r_state == S_MEM);
    assign w_ready       = w_fetch_phase ? imem_ready : dmem_ready;

    cpu_ctrl_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (!(w_fetch_phase || w_mem_phase) || w_ready),
        .hold    ((w_fetch_phase || w_mem_phase) && !w_ready),
        .expired (w_expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_FETCH;
            r_fetch_busy <= 1'b0;
            r_halted     <= 1'b0;
            r_err        <= ERR_ECALL;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (w_fetch_phase) begin
                        if (imem_ready) begin
                            r_state      <= S_DECODE;
                            r_fetch_busy <= 1'b0;
                        end else if (w_expired) begin
                            r_state      <= S_HALT;
                            r_fetch_busy <= 1'b0;
                            r_halted     <= 1'b1;
                            r_err        <= ERR_TIMEOUT;
                        end else begin
                            r_fetch_busy <= 1'b1;
                        end
                    end
                end
                S_DECODE: begin
                    if (is_exec_op(w_op)) begin
                        r_state <= S_EXEC;
                    end else begin
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
                        r_err    <= (w_op == OP_SYSTEM) ? ERR_ECALL : ERR_ILLEGAL;
                    end
                end
                S_EXEC: begin
                    if (w_op == OP_LOAD || w_op == OP_STORE)
                        r_state <= S_MEM;
                    else if (w_op == OP_BRANCH)
                        r_state <= S_FETCH;
                    else
                        r_state <= S_WB;
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        r_state <= (w_op == OP_LOAD) ? S_WB : S_FETCH;
                    end else if (w_expired) begin
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
                        r_err    <= ERR_TIMEOUT;
                    end
                end
                S_WB:    r_state <= S_FETCH;
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        imem_req = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        ir_write = 1'b0;
        pc_write = 1'b0;
        pc_src   = PC_PLUS4;
        RegWrite = 1'b0;
        alu_src  = 1'b0;
        alu_op   = ALU_ADD;
        wb_sel   = WB_ALU;
        case (r_state)
            S_FETCH: begin
                imem_req = w_fetch_phase && !w_expired;
                ir_write = w_fetch_phase && imem_ready;
                pc_write = w_fetch_phase && imem_ready;
            end
            S_EXEC: begin
                case (w_op)
                    OP_R: alu_op = {w_f7b5, w_f3};
                    OP_I: begin
                        alu_src = 1'b1;
                        alu_op  = {(w_f3 == 3'b101) && w_f7b5, w_f3};
                    end
                    OP_LOAD, OP_STORE: alu_src = 1'b1;
                    OP_BRANCH: begin
                        alu_op   = ALU_SUB;
                        pc_write = branch_taken;
                        pc_src   = PC_BRANCH;
                    end
                    OP_JAL: begin
                        pc_write = 1'b1;
                        pc_src   = PC_JAL;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                MemRead  = (w_op == OP_LOAD) && !w_expired;
                MemWrite = (w_op == OP_STORE) && !w_expired;
            end
            S_WB: begin
                RegWrite = 1'b1;
                if (w_op == OP_LOAD)
                    wb_sel = WB_MEM;
                else if (w_op == OP_JAL)
                    wb_sel = WB_PC4;
            end
            default: ;
        endcase
        // Reset must silence run/ready-driven strobes without waiting for a clock.
        if (!reset) begin
            imem_req = 1'b0;
            ir_write = 1'b0;
            pc_write = 1'b0;
        end
    end

    assign halted = r_halted;
    assign err    = r_err;

endmodule

// File: tb/tb_cpu_ctrl.sv
// tb/tb_cpu_ctrl.sv - randomized per-cycle check of cpu_ctrl against a transaction-level model
module tb_cpu_ctrl;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        run = 1'b0;
    logic [31:0] instr = 32'h0;
    logic        branch_taken = 1'b0;
    logic        imem_ready = 1'b0;
    logic        dmem_ready = 1'b0;
    logic        imem_req, MemRead, MemWrite, ir_write, pc_write, RegWrite, alu_src, halted;
    logic [1:0]  pc_src, wb_sel, err;
    logic [3:0]  alu_op;

    cpu_ctrl #(.TIMEOUT(T)) dut (
        .clk(clk), .reset(reset), .run(run), .instr(instr), .branch_taken(branch_taken),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req),
        .MemRead(MemRead), .MemWrite(MemWrite), .ir_write(ir_write), .pc_write(pc_write),
        .pc_src(pc_src), .RegWrite(RegWrite), .alu_src(alu_src), .alu_op(alu_op),
        .wb_sel(wb_sel), .halted(halted), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       imem_req, mem_read, mem_write, ir_write, pc_write;
        logic [1:0] pc_src;
        logic       reg_write, alu_src;
        logic [3:0] alu_op;
        logic [1:0] wb_sel;
        logic       halted;
        logic [1:0] err;
    } obs_t;

    typedef struct packed {
        logic [31:0] ins;
        logic        run, ir, dr, tk;
        obs_t        ex;
    } step_t;

    step_t       plan[$];
    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] m_ins;
    logic        m_tk;

    function automatic obs_t sample();
        obs_t g;
        g.imem_req = imem_req;  g.mem_read = MemRead;  g.mem_write = MemWrite;
        g.ir_write = ir_write;  g.pc_write = pc_write; g.pc_src = pc_src;
        g.reg_write = RegWrite; g.alu_src = alu_src;   g.alu_op = alu_op;
        g.wb_sel = wb_sel;      g.halted = halted;     g.err = err;
        return g;
    endfunction

    function automatic logic [3:0] exp_alu(input logic [31:0] ins);
        logic [2:0] f3;
        f3 = ins[14:12];
        if (ins[6:0] == 7'h33) return {ins[30], f3};
        if (ins[6:0] == 7'h13) return {(f3 == 3'd5) ? ins[30] : 1'b0, f3};
        if (ins[6:0] == 7'h63) return 4'b1000;
        return 4'b0000;
    endfunction

    task automatic check(input string name, input obs_t got, input obs_t exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%h exp=%h ins=%h", name, $time, got, exp, instr);
        end
    endtask

    task automatic pin(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic push(input logic rn, input logic ir, input logic dr, input obs_t e);
        step_t s;
        s.ins = m_ins; s.tk = m_tk; s.run = rn; s.ir = ir; s.dr = dr; s.ex = e;
        plan.push_back(s);
    endtask

    task automatic add_halt(input logic [1:0] code);
        obs_t e;
        e = '0; e.halted = 1'b1; e.err = code;
        for (int i = 0; i < 2; i++) push(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), e);
    endtask

    // Memory access waiting w cycles for ready: request visible while fewer than T cycles waited.
    task automatic add_access(input bit fetch, input bit load, input int w, output bit done);
        obs_t e;
        for (int k = 0; k <= w && k <= T; k++) begin
            e = '0;
            if (fetch) begin
                e.imem_req = (k < T);
                e.ir_write = (k == w);
                e.pc_write = (k == w);
                push((k == 0) ? 1'b1 : 1'($urandom_range(0, 1)), (k == w), 1'b0, e);
            end else begin
                e.mem_read  = load && (k < T);
                e.mem_write = !load && (k < T);
                push(1'($urandom_range(0, 1)), 1'b0, (k == w), e);
            end
        end
        done = (w <= T);
    endtask

    task automatic build(input logic [31:0] ins, input int iw, input int dw, input logic tk);
        obs_t       e;
        bit         done;
        logic [6:0] op;
        m_ins = ins; m_tk = tk; op = ins[6:0];
        add_access(1'b1, 1'b0, iw, done);
        if (!done) begin add_halt(2'd2); return; end
        e = '0;
        push(1'b1, 1'b0, 1'b0, e);
        if (!(op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F})) begin
            add_halt((op == 7'h73) ? 2'd0 : 2'd1);
            return;
        end
        e = '0;
        e.alu_op  = exp_alu(ins);
        e.alu_src = (op == 7'h13) || (op == 7'h03) || (op == 7'h23);
        if (op == 7'h63) begin e.pc_write = tk;   e.pc_src = 2'd1; end
        if (op == 7'h6F) begin e.pc_write = 1'b1; e.pc_src = 2'd2; end
        push(1'b1, 1'b0, 1'b0, e);
        if (op == 7'h63) return;
        if (op == 7'h03 || op == 7'h23) begin
            add_access(1'b0, op == 7'h03, dw, done);
            if (!done) begin add_halt(2'd2); return; end
            if (op == 7'h23) return;
        end
        e = '0;
        e.reg_write = 1'b1;
        e.wb_sel = (op == 7'h03) ? 2'd1 : (op == 7'h6F) ? 2'd2 : 2'd0;
        push(1'b1, 1'b0, 1'b0, e);
    endtask

    task automatic run_plan(input string name);
        step_t s;
        while (plan.size() > 0) begin
            s = plan.pop_front();
            @(negedge clk);
            instr = s.ins; run = s.run; imem_ready = s.ir; dmem_ready = s.dr; branch_taken = s.tk;
            #2;
            check(name, sample(), s.ex);
        end
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        run = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b0;
        #2 reset = 1'b0;
        #1 check(name, sample(), obs_t'(0));
        run = 1'b0; imem_ready = 1'b0;
        #1 reset = 1'b1;
    endtask

    localparam logic [31:0] I_ADD = 32'h002081B3;
    localparam logic [31:0] I_LW  = 32'h0080A283;
    localparam logic [31:0] I_BEQ = 32'h00000063;
    localparam logic [31:0] I_SW  = 32'h0020A023;
    localparam logic [31:0] I_JAL = 32'h000000EF;

    initial begin
        obs_t        z;
        logic [6:0]  ops [6];
        logic [31:0] r;
        z = '0;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F};

        repeat (2) @(negedge clk);
        #2 check("reset_state", sample(), z);
        #2 reset = 1'b1;

        pin("model_alu_sub", int'(exp_alu(32'h40208133)), 8);
        pin("model_alu_srai", int'(exp_alu(32'h4010D093)), 13);

        m_ins = I_ADD; m_tk = 1'b0;
        for (int i = 0; i < 3; i++) push(1'b0, 1'b0, 1'b0, z);
        run_plan("idle");

        build(I_ADD, 0, 0, 1'b0); pin("add_cycles", plan.size(), 4);  run_plan("add");
        build(I_LW, 0, 3, 1'b0);  pin("lw_cycles", plan.size(), 8);   run_plan("lw_wait3");
        build(I_BEQ, 0, 0, 1'b1); pin("beq_cycles", plan.size(), 3);  run_plan("beq_taken");
        build(I_BEQ, 0, 0, 1'b0); run_plan("beq_not_taken");
        build(I_SW, 0, 0, 1'b0);  pin("sw_cycles", plan.size(), 4);   run_plan("sw");
        build(I_JAL, 0, 0, 1'b0); run_plan("jal");
        build(I_ADD, T, 0, 1'b0); run_plan("fetch_ready_at_limit");
        build(I_LW, 0, T, 1'b0);  run_plan("mem_ready_at_limit");

        build(I_ADD, T + 5, 0, 1'b0); run_plan("fetch_timeout"); do_reset("reset_after_fetch_to");
        build(32'h0000007F, 0, 0, 1'b0); run_plan("illegal");    do_reset("reset_after_illegal");
        build(32'h00000073, 1, 0, 1'b0); run_plan("ecall");      do_reset("reset_after_ecall");
        build(I_LW, 0, T + 3, 1'b0);     run_plan("mem_timeout"); do_reset("reset_after_mem_to");

        build(I_LW, 0, 3, 1'b0);
        while (plan.size() > 4) void'(plan.pop_back());
        run_plan("lw_before_reset");
        do_reset("reset_mid_mem");
        build(I_ADD, 1, 0, 1'b0); run_plan("fetch_after_reset");

        for (int n = 0; n < 40; n++) begin
            r = $urandom;
            r[6:0] = ops[$urandom_range(0, 5)];
            build(r, $urandom_range(0, T), $urandom_range(0, T), 1'($urandom_range(0, 1)));
            run_plan("random");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
